// File: rtl/interval_timer_ctrl_pkg.sv
// Shared types and constants for the interval timer controller.
package interval_timer_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/interval_timer_ctrl_tc_counter.sv
// Loadable W-bit up-counter; load takes priority over enable.
module tc_counter #(
   parameter int W = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] q
);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         q <= '0;
      else if (load)
         q <= load_data;
      else if (enable)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: one-shot or periodic counting from Init to Limit.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | not timing (after reset, Stop or rejected Start)
//   RUN     | counting qualified edges toward Limit
//   DONE    | one-shot interval finished, Q parked at Limit
module interval_timer_ctrl
   import interval_timer_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Stop,
   input  logic         Mode,
   input  logic [W-1:0] Init,
   input  logic [W-1:0] Limit,
   input  logic         CntEn,
   output logic [W-1:0] Q,
   output logic         Busy,
   output logic         Tick,
   output logic         Done,
   output logic         Err
);

   state_t         state;
   logic [W-1:0]   init_r;
   logic [W-1:0]   limit_r;
   logic           mode_r;

   logic           start_ok;
   logic           count_cyc;
   logic           at_limit;
   logic           cnt_load;
   logic           cnt_enable;
   logic [W-1:0]   cnt_data;

   assign start_ok  = Start && !Stop && (Init <= Limit);
   assign at_limit  = (Q == limit_r);
   // Stop and Start both pre-empt counting on the edge they arrive.
   assign count_cyc = (state == ST_RUN) && !Stop && !Start && CntEn;

   assign cnt_load   = start_ok || (count_cyc && at_limit && (mode_r == MODE_PERIODIC));
   assign cnt_enable = count_cyc && !at_limit;
   assign cnt_data   = start_ok ? Init : init_r;

   tc_counter #(.W(W)) u_counter (
      .Clock     (Clock),
      .Reset     (Reset),
      .load      (cnt_load),
      .enable    (cnt_enable),
      .load_data (cnt_data),
      .q         (Q)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         Busy    <= 1'b0;
         Tick    <= 1'b0;
         Done    <= 1'b0;
         Err     <= 1'b0;
         init_r  <= '0;
         limit_r <= '0;
         mode_r  <= MODE_ONESHOT;
      end else begin
         Tick <= 1'b0;
         if (Stop) begin
            if (state == ST_RUN) begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
            end
         end else if (Start) begin
            Done <= 1'b0;
            if (Init <= Limit) begin
               state   <= ST_RUN;
               Busy    <= 1'b1;
               Err     <= 1'b0;
               init_r  <= Init;
               limit_r <= Limit;
               mode_r  <= Mode;
            end else begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               Err   <= 1'b1;
            end
         end else if (count_cyc && at_limit) begin
            Tick <= 1'b1;
            if (mode_r == MODE_ONESHOT) begin
               state <= ST_DONE;
               Busy  <= 1'b0;
               Done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl.
module tb_interval_timer_ctrl;
   import interval_timer_ctrl_pkg::*;

   localparam int W = 4;

   logic         Clock = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic         Stop  = 1'b0;
   logic         Mode  = 1'b0;
   logic [W-1:0] Init  = '0;
   logic [W-1:0] Limit = '0;
   logic         CntEn = 1'b0;
   logic [W-1:0] Q;
   logic         Busy, Tick, Done, Err;

   int checks   = 0;
   int failures = 0;

   interval_timer_ctrl #(.W(W)) dut (
      .Clock (Clock), .Reset (Reset), .Start (Start), .Stop (Stop),
      .Mode  (Mode),  .Init  (Init),  .Limit (Limit), .CntEn (CntEn),
      .Q     (Q),     .Busy  (Busy),  .Tick  (Tick),  .Done  (Done),
      .Err   (Err)
   );

   always #5 Clock = ~Clock;

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic start_run(input logic [W-1:0] i, input logic [W-1:0] l,
                            input logic m, input logic en);
      Init = i; Limit = l; Mode = m; CntEn = en; Start = 1'b1;
      cyc();
      Start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({Q, Busy, Tick, Done, Err} !== {4'd0, 4'b0000}) begin
         failures++;
         $display("FAIL reset_initial: Q=%0d B=%b T=%b D=%b E=%b, need all 0", Q, Busy, Tick, Done, Err);
      end
      cyc();
      Reset = 1'b0;
      cyc();
      // reset mid-run must clear outputs without a clock edge
      start_run(4'd4, 4'd12, MODE_ONESHOT, 1'b1);
      cyc(); cyc();
      checks++;
      if (Q !== 4'd6 || Busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_prerun: Q=%0d Busy=%b, need 6/1", Q, Busy);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if ({Q, Busy, Tick, Done, Err} !== {4'd0, 4'b0000}) begin
         failures++;
         $display("FAIL reset_midrun: Q=%0d B=%b T=%b D=%b E=%b, need all 0", Q, Busy, Tick, Done, Err);
      end
      #1 Reset = 1'b0;
      cyc();
      checks++;
      if (Q !== 4'd0 || Busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_after: Q=%0d Busy=%b, need 0/0", Q, Busy);
      end
   endtask

   task automatic test_oneshot();
      start_run(4'd3, 4'd6, MODE_ONESHOT, 1'b1);
      for (int i = 0; i <= 3; i++) begin
         if (i > 0) cyc();
         checks++;
         if (Q !== 4'(3 + i) || Busy !== 1'b1 || Tick !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_count[%0d]: Q=%0d B=%b T=%b D=%b, need %0d/1/0/0", i, Q, Busy, Tick, Done, 3 + i);
         end
      end
      cyc();
      checks++;
      if (Tick !== 1'b1 || Done !== 1'b1 || Busy !== 1'b0 || Q !== 4'd6) begin
         failures++;
         $display("FAIL oneshot_tc: Q=%0d B=%b T=%b D=%b, need 6/0/1/1", Q, Busy, Tick, Done);
      end
      cyc();
      checks++;
      if (Tick !== 1'b0 || Done !== 1'b1 || Q !== 4'd6) begin
         failures++;
         $display("FAIL oneshot_after: Q=%0d T=%b D=%b, need 6/0/1", Q, Tick, Done);
      end
   endtask

   task automatic test_periodic();
      logic [3:0] exp_q [8] = '{4'd15, 4'd15, 4'd14, 4'd14, 4'd15, 4'd15, 4'd14, 4'd14};
      logic       exp_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      start_run(4'd14, 4'd15, MODE_PERIODIC, 1'b0);
      checks++;
      if (Q !== 4'd14 || Busy !== 1'b1 || Done !== 1'b0) begin
         failures++;
         $display("FAIL periodic_start: Q=%0d B=%b D=%b, need 14/1/0", Q, Busy, Done);
      end
      for (int k = 0; k < 8; k++) begin
         CntEn = (k % 2 == 0);
         cyc();
         checks++;
         if (Q !== exp_q[k] || Tick !== exp_t[k] || Busy !== 1'b1) begin
            failures++;
            $display("FAIL periodic[%0d]: Q=%0d T=%b B=%b, need %0d/%b/1", k, Q, Tick, Busy, exp_q[k], exp_t[k]);
         end
      end
      // Init == Limit ticks on every qualified edge
      start_run(4'd7, 4'd7, MODE_PERIODIC, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (Q !== 4'd7 || Tick !== 1'b1 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL periodic_eq[%0d]: Q=%0d T=%b B=%b, need 7/1/1", k, Q, Tick, Busy);
         end
      end
   endtask

   task automatic test_full_range();
      start_run(4'd0, 4'd15, MODE_ONESHOT, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         cyc();
         checks++;
         if (Q !== 4'(i) || Tick !== 1'b0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL full_count[%0d]: Q=%0d T=%b B=%b, need %0d/0/1", i, Q, Tick, Busy, i);
         end
      end
      cyc();
      checks++;
      if (Q !== 4'd15 || Tick !== 1'b1 || Done !== 1'b1 || Busy !== 1'b0) begin
         failures++;
         $display("FAIL full_tc: Q=%0d T=%b D=%b B=%b, need 15/1/1/0", Q, Tick, Done, Busy);
      end
      cyc(); cyc();
      checks++;
      if (Q !== 4'd15 || Tick !== 1'b0 || Done !== 1'b1) begin
         failures++;
         $display("FAIL full_nowrap: Q=%0d T=%b D=%b, need 15/0/1", Q, Tick, Done);
      end
   endtask

   task automatic test_stop();
      start_run(4'd2, 4'd10, MODE_ONESHOT, 1'b1);
      cyc(); cyc(); cyc();
      Stop = 1'b1;
      cyc();
      Stop = 1'b0;
      checks++;
      if (Q !== 4'd5 || Busy !== 1'b0 || Tick !== 1'b0 || Done !== 1'b0) begin
         failures++;
         $display("FAIL stop_run: Q=%0d B=%b T=%b D=%b, need 5/0/0/0", Q, Busy, Tick, Done);
      end
      cyc();
      checks++;
      if (Q !== 4'd5 || Busy !== 1'b0) begin
         failures++;
         $display("FAIL stop_idle_hold: Q=%0d B=%b, need 5/0", Q, Busy);
      end
      Init = 4'd1; Limit = 4'd8; Start = 1'b1; Stop = 1'b1;
      cyc();
      Start = 1'b0; Stop = 1'b0;
      checks++;
      if (Q !== 4'd5 || Busy !== 1'b0 || Err !== 1'b0) begin
         failures++;
         $display("FAIL stop_beats_start: Q=%0d B=%b E=%b, need 5/0/0", Q, Busy, Err);
      end
   endtask

   task automatic test_error();
      start_run(4'd9, 4'd4, MODE_ONESHOT, 1'b1);
      checks++;
      if (Err !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Q !== 4'd5) begin
         failures++;
         $display("FAIL err_set: E=%b B=%b D=%b Q=%0d, need 1/0/0/5", Err, Busy, Done, Q);
      end
      cyc();
      checks++;
      if (Err !== 1'b1 || Q !== 4'd5) begin
         failures++;
         $display("FAIL err_sticky: E=%b Q=%0d, need 1/5", Err, Q);
      end
      start_run(4'd2, 4'd4, MODE_ONESHOT, 1'b0);
      checks++;
      if (Err !== 1'b0 || Busy !== 1'b1 || Q !== 4'd2) begin
         failures++;
         $display("FAIL err_clear: E=%b B=%b Q=%0d, need 0/1/2", Err, Busy, Q);
      end
   endtask

   task automatic test_back_to_back();
      CntEn = 1'b1;
      cyc();
      checks++;
      if (Q !== 4'd3) begin
         failures++;
         $display("FAIL b2b_pre: Q=%0d, need 3", Q);
      end
      start_run(4'd1, 4'd3, MODE_ONESHOT, 1'b1);
      checks++;
      if (Q !== 4'd1 || Busy !== 1'b1 || Tick !== 1'b0) begin
         failures++;
         $display("FAIL b2b_restart: Q=%0d B=%b T=%b, need 1/1/0", Q, Busy, Tick);
      end
      cyc(); cyc(); cyc();
      checks++;
      if (Q !== 4'd3 || Tick !== 1'b1 || Done !== 1'b1) begin
         failures++;
         $display("FAIL b2b_tc: Q=%0d T=%b D=%b, need 3/1/1", Q, Tick, Done);
      end
      // Err must also clear on an asynchronous reset
      start_run(4'd12, 4'd3, MODE_ONESHOT, 1'b1);
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (Err !== 1'b0 || Done !== 1'b0 || Q !== 4'd0) begin
         failures++;
         $display("FAIL reset_err: E=%b D=%b Q=%0d, need 0/0/0", Err, Done, Q);
      end
      #1 Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_full_range();
      test_stop();
      test_error();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Programmable interval timer built around a loadable up-counter with enable.
- An FSM sequences load, count and terminal-count detection.
- Supports one-shot and periodic modes, count qualification by an external enable/prescaler strobe, stop/restart, and parameter error flagging.
- Sits between a register/control front end and any logic that needs periodic or single timed events.

Parameters:
- W, 4, counter, init and limit width in bits.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request; captures Init/Limit/Mode and (re)starts timing.
- Stop  in  1  aborts a running interval.
- Mode  in  1  0 = one-shot, 1 = periodic; sampled with Start.
- Init  in  W  start value of each interval; sampled with Start.
- Limit  in  W  terminal value of each interval; sampled with Start.
- CntEn  in  1  count qualifier; counter advances only on edges where CntEn=1.
- Q  out  W  current count.
- Busy  out  1  high while in RUN.
- Tick  out  1  one-cycle registered pulse on terminal count.
- Done  out  1  level; one-shot interval completed.
- Err  out  1  sticky; the last Start had Init > Limit.

Behaviour:
- Reset, asynchronous, effective immediately including mid-run:
  - state = IDLE
  - Q = 0
  - Busy = Tick = Done = Err = 0
  - captured Init, Limit and Mode registers = 0
- States: IDLE, RUN, DONE. All outputs are registered.
- Priority within a cycle: Reset > Stop > Start > count.
- Stop:
  - In RUN: next state IDLE; Q holds; Busy = 0; no Tick.
  - In IDLE or DONE: no effect, except that it suppresses a simultaneous Start.
- Valid Start (Init <= Limit), accepted in any state including RUN:
  - Capture Init, Limit and Mode; load Q = Init on the same edge.
  - Next state RUN; Busy = 1; Done = 0; Err = 0.
  - In RUN this is a restart; CntEn on that edge is ignored.
- Invalid Start (Init > Limit):
  - Next state IDLE; Err = 1; Busy = 0; Done = 0; Q unchanged.
- RUN with CntEn = 0: Q holds.
- RUN with CntEn = 1 and Q != Limit: Q <= Q + 1.
- RUN with CntEn = 1 and Q == Limit:
  - Tick = 1 for exactly one cycle.
  - Periodic: Q <= Init; stay in RUN.
  - One-shot: Q holds Limit; next state DONE; Busy = 0; Done = 1.
- Interval length is Limit - Init + 1 qualified edges, counted from the Start edge to the Tick edge. Init == Limit gives a Tick on every qualified edge.
- No wrap-around: Q never exceeds Limit, so Limit = 2^W-1 does not overflow.
- Tick is 0 in every cycle other than the terminal-count cycle.
- DONE holds until a Start or Reset.

Decomposition:
- Shared package holds:
  - State enum (IDLE, RUN, DONE).
  - Mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1).
- One sub-module: tc_counter.
  - Loadable W-bit up-counter; inputs Clock, Reset, load, enable, load data; output Q.
  - Asynchronous active-high reset to 0; load has priority over enable.
- The FSM in interval_timer_ctrl drives load/enable and does the Q == Limit compare.

Test Plan:
- Reset pulse, including while in RUN: Q = 0, Busy = Tick = Done = Err = 0 without waiting for a clock edge.
- One-shot, Init = 3, Limit = 6, CntEn = 1, Start at edge 0:
  - Q = 3, 4, 5, 6 after edges 0 to 3.
  - After edge 4: Tick = 1, Done = 1, Busy = 0, Q = 6.
  - Tick = 0 after edge 5.
- Periodic, Init = 14, Limit = 15, CntEn high every other cycle:
  - Q sequence 14, 15, 14, 15, …
  - Tick every 4 clocks; Busy stays 1.
- Init = 0, Limit = 15, one-shot, CntEn = 1:
  - Tick after the 16th edge; Q = 15 with no wrap to 0.
- Stop at Q = 5: IDLE, Q = 5, Busy = 0, no Tick. Start and Stop in the same cycle: Stop wins, Busy = 0.
- Start with Init = 9, Limit = 4: Err = 1, Busy = 0, Q unchanged. A following Start with Init = 2, Limit = 4 clears Err, Busy = 1, Q = 2.
